// File: rtl/chip_sequencer_pkg.sv
// rtl/chip_sequencer_pkg.sv - shared types and timing defaults for the chip sequencer
// Purpose: opcode and FSM state enums, default strobe timing, width helper.
// Ports: none (package chip_pkg).
package chip_pkg;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_PROG_SET   = 3'd1,
    OP_PROG_RESET = 3'd2,
    OP_LOAD_SEED  = 3'd3,
    OP_LOAD_MEM   = 3'd4,
    OP_INFER      = 3'd5,
    OP_READ1      = 3'd6,
    OP_READ8      = 3'd7
  } chip_op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    PULSE  = 3'd2,
    HOLD   = 3'd3,
    SAMPLE = 3'd4
  } seq_state_e;

  localparam int DEF_SETUP_CYCLES = 2;
  localparam int DEF_PROG_CYCLES  = 16;
  localparam int DEF_HOLD_CYCLES  = 2;
  localparam int DEF_READ_LAT     = 2;
  // Longest inference pulse: cmd_data+1 with an 8-bit cmd_data.
  localparam int MAX_INFER_CYCLES = 256;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/chip_sequencer_if.sv
// rtl/chip_sequencer_if.sv - memristor chip pin bundle
// Purpose: groups every chip pin; the sequencer drives it through Master.
// Ports (signals): clk, CBL, CBLEN, CWL, inference, load_seed, read_1, read_8,
//   load_mem, read_out, stoch_log, addr_full_row[7:0], addr_full_col[7:0],
//   seeds[7:0] (master -> chip); bit_out[3:0] (chip -> master).
interface chip_ports;
  logic       clk;
  logic       CBL;
  logic       CBLEN;
  logic       CWL;
  logic       inference;
  logic       load_seed;
  logic       read_1;
  logic       read_8;
  logic       load_mem;
  logic       read_out;
  logic       stoch_log;
  logic [7:0] addr_full_row;
  logic [7:0] addr_full_col;
  logic [7:0] seeds;
  logic [3:0] bit_out;

  modport Master (
    output clk, CBL, CBLEN, CWL, inference, load_seed, read_1, read_8,
           load_mem, read_out, stoch_log, addr_full_row, addr_full_col, seeds,
    input  bit_out
  );

  modport Slave (
    input  clk, CBL, CBLEN, CWL, inference, load_seed, read_1, read_8,
           load_mem, read_out, stoch_log, addr_full_row, addr_full_col, seeds,
    output bit_out
  );
endinterface

// File: rtl/chip_sequencer_timer.sv
// rtl/chip_sequencer_timer.sv - loadable down-counter with done flag
// Purpose: times each sequencer state; a state loaded with N lasts N+1 cycles.
// Ports: clk, rst (sync active-high), load, load_val[W-1:0], done (count is zero).
module seq_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/chip_sequencer.sv
// rtl/chip_sequencer.sv - host-command to chip-strobe sequencer
// Purpose: accepts host commands, plays SETUP/PULSE/HOLD/SAMPLE strobe
//   sequences on the chip pins, returns sampled bit_out on a response channel.
// Ports: clk, rst (sync active-high); cmd_valid/cmd_ready/cmd_op/cmd_row/
//   cmd_col/cmd_data (command in); rsp_valid/rsp_ready/rsp_data (response out);
//   busy (FSM not idle); chip (chip_ports.Master, all chip pins).
module chip_sequencer
  import chip_pkg::*;
#(
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int PROG_CYCLES  = DEF_PROG_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int READ_LAT     = DEF_READ_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_row,
  input  logic [7:0]  cmd_col,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [3:0]  rsp_data,
  output logic        busy,
  chip_ports.Master   chip
);

  localparam int MAX_CNT = max_int(max_int(PROG_CYCLES, MAX_INFER_CYCLES),
                                   max_int(max_int(SETUP_CYCLES, HOLD_CYCLES), READ_LAT));
  localparam int CW = $clog2(MAX_CNT) + 1;

  seq_state_e      state;
  seq_state_e      nxt_state;
  chip_op_e        op_q;
  logic [7:0]      data_q;
  logic            accept;
  logic            needs_rsp;
  logic            in_pulse;
  logic            tmr_load;
  logic            tmr_done;
  logic [CW-1:0]   tmr_val;
  logic [CW-1:0]   pulse_load;

  assign chip.clk  = clk;
  assign cmd_ready = !rst && (state == IDLE) && !rsp_valid;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != IDLE);
  assign needs_rsp = (op_q == OP_INFER) || (op_q == OP_READ1) || (op_q == OP_READ8);
  assign in_pulse  = (nxt_state == PULSE);
  // Each state entry reloads the timer; IDLE entry loads zero harmlessly.
  assign tmr_load  = (nxt_state != state);

  // Timer value is "cycles in state minus one".
  always_comb begin
    pulse_load = '0;
    case (op_q)
      OP_PROG_SET, OP_PROG_RESET: pulse_load = CW'(PROG_CYCLES - 1);
      OP_INFER:                   pulse_load = {{(CW-8){1'b0}}, data_q};
      default:                    pulse_load = '0;
    endcase
  end

  // The SETUP timer is loaded with SETUP_CYCLES (not minus one): its first
  // cycle is the command-latch cycle, giving accept->IDLE = 1+SETUP+pulse+HOLD.
  always_comb begin
    nxt_state = state;
    tmr_val   = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          nxt_state = SETUP;
          tmr_val   = CW'(SETUP_CYCLES);
        end
      end
      SETUP: begin
        if (op_q == OP_NOP) begin
          nxt_state = IDLE;
        end else if (tmr_done) begin
          nxt_state = PULSE;
          tmr_val   = pulse_load;
        end
      end
      PULSE: begin
        if (tmr_done) begin
          if (HOLD_CYCLES > 0) begin
            nxt_state = HOLD;
            tmr_val   = CW'(HOLD_CYCLES - 1);
          end else if (needs_rsp) begin
            nxt_state = SAMPLE;
            tmr_val   = CW'(READ_LAT - 1);
          end else begin
            nxt_state = IDLE;
          end
        end
      end
      HOLD: begin
        if (tmr_done) begin
          if (needs_rsp) begin
            nxt_state = SAMPLE;
            tmr_val   = CW'(READ_LAT - 1);
          end else begin
            nxt_state = IDLE;
          end
        end
      end
      SAMPLE: begin
        if (tmr_done) begin
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  seq_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Strobes decode from the next state so they change on the same edge as
  // the state register; only one op group can be in PULSE at a time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      op_q               <= OP_NOP;
      data_q             <= '0;
      chip.CBL           <= 1'b0;
      chip.CBLEN         <= 1'b0;
      chip.CWL           <= 1'b0;
      chip.inference     <= 1'b0;
      chip.stoch_log     <= 1'b0;
      chip.load_seed     <= 1'b0;
      chip.load_mem      <= 1'b0;
      chip.read_1        <= 1'b0;
      chip.read_8        <= 1'b0;
      chip.read_out      <= 1'b0;
      chip.addr_full_row <= '0;
      chip.addr_full_col <= '0;
      chip.seeds         <= '0;
      rsp_valid          <= 1'b0;
      rsp_data           <= '0;
    end else begin
      state <= nxt_state;

      if (accept) begin
        op_q               <= chip_op_e'(cmd_op);
        data_q             <= cmd_data;
        chip.addr_full_row <= cmd_row;
        chip.addr_full_col <= cmd_col;
      end else if (nxt_state == IDLE) begin
        chip.addr_full_row <= '0;
        chip.addr_full_col <= '0;
      end

      chip.CWL       <= in_pulse && ((op_q == OP_PROG_SET) || (op_q == OP_PROG_RESET));
      chip.CBLEN     <= in_pulse && ((op_q == OP_PROG_SET) || (op_q == OP_PROG_RESET));
      chip.CBL       <= in_pulse && (op_q == OP_PROG_SET);
      chip.inference <= in_pulse && (op_q == OP_INFER);
      chip.stoch_log <= in_pulse && (op_q == OP_INFER);
      chip.load_seed <= in_pulse && (op_q == OP_LOAD_SEED);
      chip.load_mem  <= in_pulse && (op_q == OP_LOAD_MEM);
      chip.read_1    <= in_pulse && (op_q == OP_READ1);
      chip.read_8    <= in_pulse && (op_q == OP_READ8);
      chip.read_out  <= (nxt_state == SAMPLE);

      // Seeds persist after the load pulse so the chip sees a stable value.
      if (in_pulse && (state != PULSE) && (op_q == OP_LOAD_SEED)) begin
        chip.seeds <= data_q;
      end

      if ((state == SAMPLE) && tmr_done) begin
        rsp_data  <= chip.bit_out;
        rsp_valid <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chip_sequencer.sv
// tb/tb_chip_sequencer.sv - self-checking bench for chip_sequencer
module tb_chip_sequencer;
  import chip_pkg::*;

  localparam int S = 2;
  localparam int P = 16;
  localparam int H = 2;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = '0;
  logic [7:0] cmd_row = '0;
  logic [7:0] cmd_col = '0;
  logic [7:0] cmd_data = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [3:0] rsp_data;
  logic       busy;

  int   errors = 0;
  int   checks = 0;
  bit   keep_valid = 1'b0;
  logic [7:0] seeds_exp = '0;

  always #5 clk = ~clk;

  chip_ports chip ();

  chip_sequencer #(
    .SETUP_CYCLES (S),
    .PROG_CYCLES  (P),
    .HOLD_CYCLES  (H),
    .READ_LAT     (R)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .chip      (chip)
  );

  logic [9:0] stb;
  assign stb = {chip.CBL, chip.CBLEN, chip.CWL, chip.inference, chip.load_seed,
                chip.read_1, chip.read_8, chip.load_mem, chip.read_out, chip.stoch_log};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] pulse_pat(input logic [2:0] op);
    case (op)
      3'd1:    return 10'b1110000000;
      3'd2:    return 10'b0110000000;
      3'd3:    return 10'b0000100000;
      3'd4:    return 10'b0000000100;
      3'd5:    return 10'b0001000001;
      3'd6:    return 10'b0000010000;
      3'd7:    return 10'b0000001000;
      default: return 10'b0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("overlap", 32'($onehot0({chip.CWL | chip.CBLEN | chip.CBL,
                                     chip.inference | chip.stoch_log,
                                     chip.load_seed, chip.load_mem, chip.read_1,
                                     chip.read_8, chip.read_out})), 32'd1);
    end
  end

  // Called at a negedge with the sequencer idle; returns at a negedge, idle.
  // Cycle k=1 is the first cycle after the accepting edge.
  task automatic run_op(input logic [2:0] op, input logic [7:0] row, input logic [7:0] col,
                        input logic [7:0] data, input logic [3:0] bitval, input int bp);
    int  p;
    int  busy_len;
    int  samp_last;
    bit  rsp;
    logic [9:0] exp_stb;
    rsp = (op == 3'd5) || (op == 3'd6) || (op == 3'd7);
    if (op == 3'd0) p = 0;
    else if (op == 3'd1 || op == 3'd2) p = P;
    else if (op == 3'd5) p = int'(data) + 1;
    else p = 1;
    busy_len  = (op == 3'd0) ? 1 : 1 + S + p + H + (rsp ? R : 0);
    samp_last = rsp ? S + 1 + p + H + R : -1;

    check("ready_on_offer", cmd_ready, 1);
    check("idle_on_offer", busy, 0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_row   = row;
    cmd_col   = col;
    cmd_data  = data;

    for (int k = 1; k <= busy_len + 1; k++) begin
      @(negedge clk);
      if (k == 1 && !keep_valid) cmd_valid = 1'b0;
      chip.bit_out = (k == samp_last) ? bitval : 4'($urandom);
      if (op == 3'd3 && k == S + 2) seeds_exp = data;
      exp_stb = 10'b0;
      if (k >= S + 2 && k <= S + 1 + p) exp_stb = pulse_pat(op);
      if (rsp && k >= S + 2 + p + H && k <= S + 1 + p + H + R) exp_stb = 10'b0000000010;
      check("strobes", stb, exp_stb);
      check("busy", busy, (k <= busy_len) ? 1 : 0);
      check("row", chip.addr_full_row, (k <= busy_len) ? row : 8'h00);
      check("col", chip.addr_full_col, (k <= busy_len) ? col : 8'h00);
      check("seeds", chip.seeds, seeds_exp);
      check("rsp_valid", rsp_valid, (rsp && k == busy_len + 1) ? 1 : 0);
      check("cmd_ready", cmd_ready, (!rsp && k == busy_len + 1) ? 1 : 0);
    end

    if (rsp) begin
      check("rsp_data", rsp_data, bitval);
      for (int j = 0; j < bp; j++) begin
        cmd_valid = 1'b1;
        @(negedge clk);
        check("bp_rsp_valid", rsp_valid, 1);
        check("bp_rsp_data", rsp_data, bitval);
        check("bp_cmd_ready", cmd_ready, 0);
        check("bp_busy", busy, 0);
      end
      cmd_valid = keep_valid;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("rsp_consumed", rsp_valid, 0);
      check("post_rsp_busy", busy, 0);
      check("post_rsp_ready", cmd_ready, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    chip.bit_out = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_strobes", stb, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_row", chip.addr_full_row, 0);
    check("rst_col", chip.addr_full_col, 0);
    check("rst_seeds", chip.seeds, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", cmd_ready, 1);

    run_op(3'd1, 8'h12, 8'h34, 8'h00, 4'h0, 0);
    run_op(3'd3, 8'h01, 8'h02, 8'hA5, 4'h0, 0);
    run_op(3'd5, 8'h05, 8'h06, 8'h03, 4'hB, 3);
    run_op(3'd7, 8'h07, 8'h08, 8'h00, 4'h6, 10);
    run_op(3'd0, 8'h09, 8'h0A, 8'h00, 4'h0, 0);
    run_op(3'd2, 8'hFF, 8'h80, 8'h00, 4'h0, 0);
    run_op(3'd4, 8'h11, 8'h22, 8'h00, 4'h0, 0);
    run_op(3'd6, 8'h33, 8'h44, 8'h00, 4'h9, 1);

    // Reset in the middle of a PROG_SET pulse.
    check("ready_pre_midrst", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_row   = 8'h5A;
    cmd_col   = 8'hC3;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    check("midrst_pulse_on", stb, 10'b1110000000);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_strobes", stb, 0);
    check("midrst_busy", busy, 0);
    check("midrst_row", chip.addr_full_row, 0);
    check("midrst_seeds", chip.seeds, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seeds_exp = 8'h00;
    @(negedge clk);
    check("midrst_ready_after", cmd_ready, 1);
    check("midrst_rsp_valid", rsp_valid, 0);

    // Back-to-back with cmd_valid held across the whole group.
    keep_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
             8'($urandom_range(0, 20)), 4'($urandom), int'($urandom_range(0, 2)));
    end
    keep_valid = 1'b0;
    cmd_valid  = 1'b0;
    @(negedge clk);
    check("b2b_idle", busy, 0);

    for (int i = 0; i < 20; i++) begin
      keep_valid = 1'($urandom_range(0, 1));
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
             8'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    end
    keep_valid = 1'b0;
    cmd_valid  = 1'b0;
    @(negedge clk);
    check("final_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
